octa_load_sched: RTL and testbench
==================================

# octa_load_sched

Session sequencer for the octa-parallel PPR diffusion datapath. It loads the PARALLEL score-table and subgraph BRAM banks from a PS-side stream, zero-fills the score-sum banks, and releases the diffusion core via `rdy_flag`. It waits for the core to finish, then streams the score-sum banks back out. It owns all three BRAM sets whenever `rdy_flag` is 0 and relinquishes them while it is 1.

## Interface
Parameters:
- ADDR_WIDTH, 13, BRAM address width
- DEPTH, 8192, words per score/subgraph bank; score-sum banks hold DEPTH/2
- DATA_WIDTH, 32, word width
- PARALLEL, 8, number of banks per table

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin session (sampled in IDLE only)
- load_len  in  ADDR_WIDTH+1  beats per table, 0..DEPTH; values above DEPTH are clamped to DEPTH
- in_valid  in  1  load stream valid
- in_ready  out  1  load stream ready
- in_data  in  DATA_WIDTH*PARALLEL  one word per bank; bank a is slice [a*DATA_WIDTH +: DATA_WIDTH]
- s_addr / g_addr  out  ADDR_WIDTH  score / subgraph bank address, common to all banks
- s_we / g_we  out  PARALLEL  per-bank write enable
- s_wdata / g_wdata  out  DATA_WIDTH*PARALLEL  write data
- sum_addr  out  ADDR_WIDTH  score-sum address
- sum_we  out  PARALLEL  score-sum write enable
- sum_wdata  out  DATA_WIDTH*PARALLEL  always 0
- sum_rdata  in  DATA_WIDTH*PARALLEL  score-sum read data, valid 1 cycle after address
- rdy_flag  out  1  diffusion core enable; also the BRAM ownership mux select
- diff_done  in  1  core completion, level or pulse
- out_valid  out  1  readback valid
- out_ready  in  1  readback ready
- out_data  out  DATA_WIDTH*PARALLEL  readback word
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at session end
- run_cycles  out  32  cycles spent in RUN, saturating at 2^32-1

## Operation
- All outputs are registered. Reset forces state IDLE and drives every output to 0.
- IDLE: `start`=1 clears the counters and `run_cycles`, latches `load_len` as L, and goes to LOAD_S. If L=0, it goes to CLR_SUM instead.
- LOAD_S: `in_ready`=1. On the k-th handshake (k=0..L-1), the next cycle drives `s_we`=all-ones, `s_addr`=k and `s_wdata`=`in_data`. After beat L-1 the block goes to LOAD_G.
- LOAD_G: same behaviour targeting the g_* ports, with k restarting at 0. After beat L-1 the block goes to CLR_SUM.
- CLR_SUM: writes zeros to `sum_addr` 0..DEPTH/2-1, one address per cycle, with `sum_we`=all-ones. It then goes to RUN.
- RUN: `rdy_flag`=1; all we outputs are 0 and all address outputs hold 0. `run_cycles` increments each cycle. When `diff_done`=1 is sampled, the block goes to RD_ADDR and `rdy_flag` drops on the next cycle.
- RD_ADDR: drives `sum_addr`=j (j=0..DEPTH/2-1), then goes to RD_WAIT.
- RD_WAIT: captures `sum_rdata` into `out_data`, sets `out_valid`=1, and goes to RD_OUT.
- RD_OUT: holds `out_valid`/`out_data` stable until `out_ready`. On handshake it clears `out_valid`; if j=DEPTH/2-1 it goes to DONE, otherwise it increments j and goes to RD_ADDR.
- DONE: `done`=1 for one cycle, then the block returns to IDLE.
- `start` outside IDLE is ignored. `in_valid` outside the LOAD states is not accepted (`in_ready`=0). `diff_done` outside RUN is ignored.
- Counters are ADDR_WIDTH+1 bits wide, so L=DEPTH terminates without wrap.
- Asserting `rst` mid-session aborts immediately: `rdy_flag`, all we and `out_valid` go to 0 asynchronously, and BRAM contents are left undefined.

## Timing
- Load throughput is 1 beat/cycle. A write appears 1 cycle after its handshake.
- Cycle-level sequence:
  - LOAD_S exits the cycle after beat L-1.
  - LOAD_G exits the cycle after its final beat.
  - CLR_SUM occupies exactly DEPTH/2 cycles.
  - `rdy_flag` rises on the first RUN cycle.
- `diff_done` sampled at cycle n gives `rdy_flag`=0 at n+1.
- `run_cycles` equals the number of cycles with `rdy_flag`=1.
- Readback takes 3 cycles per word with `out_ready` held high. The total is 3*DEPTH/2 cycles plus stall cycles.
- `done` occurs 1 cycle after the final out handshake. `busy` falls the cycle after `done`.

## Test plan
- Parameters DEPTH=16, PARALLEL=2, L=16, incrementing data, `in_valid` always 1:
  - `s_we` is high for 16 consecutive cycles with addresses 0..15, followed by 16 `g_we` cycles.
  - `sum_we` is then high for 8 cycles with addresses 0..7, after which `rdy_flag`=1.
- Random `in_valid` gaps with L=5: exactly 5 score writes and 5 subgraph writes occur, with addresses contiguous and data matching the stream order.
- L=0: zero s/g writes; CLR_SUM follows directly after IDLE.
- `diff_done` asserted 37 cycles into RUN: `run_cycles`=37, `rdy_flag` is high for exactly 37 cycles, and a `start` pulse during RUN has no effect.
- Readback with a model BRAM holding sum[j]=j+100 and random `out_ready` stalls:
  - 8 words 100..107 are delivered in order.
  - Data stays stable while stalled.
  - A single `done` pulse follows, then `busy`=0.
- `rst` pulsed mid-LOAD_G and again mid-RUN: all outputs are 0 immediately, state is IDLE, and a fresh `start` completes a full session correctly.

Source files
------------

// File: rtl/octa_load_sched.sv
// rtl/octa_load_sched.sv - session sequencer: bank load, score-sum clear, core release, readback
module octa_load_sched #(
    parameter int ADDR_WIDTH = 13,
    parameter int DEPTH      = 8192,
    parameter int DATA_WIDTH = 32,
    parameter int PARALLEL   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_WIDTH:0]            load_len,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH*PARALLEL-1:0] in_data,
    output logic [ADDR_WIDTH-1:0]          s_addr,
    output logic [PARALLEL-1:0]            s_we,
    output logic [DATA_WIDTH*PARALLEL-1:0] s_wdata,
    output logic [ADDR_WIDTH-1:0]          g_addr,
    output logic [PARALLEL-1:0]            g_we,
    output logic [DATA_WIDTH*PARALLEL-1:0] g_wdata,
    output logic [ADDR_WIDTH-1:0]          sum_addr,
    output logic [PARALLEL-1:0]            sum_we,
    output logic [DATA_WIDTH*PARALLEL-1:0] sum_wdata,
    input  logic [DATA_WIDTH*PARALLEL-1:0] sum_rdata,
    output logic                           rdy_flag,
    input  logic                           diff_done,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH*PARALLEL-1:0] out_data,
    output logic                           busy,
    output logic                           done,
    output logic [31:0]                    run_cycles
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int DW = DATA_WIDTH * PARALLEL;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] HALF_LAST = CW'(DEPTH / 2 - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_S, LOAD_G, CLR_SUM, RUN, RD_ADDR, RD_WAIT, RD_OUT, DONE_S
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, len_q, len_d, len_clamped;
    logic in_ready_q, in_ready_d, rdy_flag_q, rdy_flag_d;
    logic out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
    logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d, g_addr_q, g_addr_d, sum_addr_q, sum_addr_d;
    logic [PARALLEL-1:0] s_we_q, s_we_d, g_we_q, g_we_d, sum_we_q, sum_we_d;
    logic [DW-1:0] s_wdata_q, s_wdata_d, g_wdata_q, g_wdata_d, out_data_q, out_data_d;
    logic [31:0] run_cycles_q, run_cycles_d;
    logic hs_in;

    // State and registered outputs; reset drops enables and rdy_flag at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            in_ready_q   <= 1'b0;
            rdy_flag_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            s_addr_q     <= '0;
            g_addr_q     <= '0;
            sum_addr_q   <= '0;
            s_we_q       <= '0;
            g_we_q       <= '0;
            sum_we_q     <= '0;
            s_wdata_q    <= '0;
            g_wdata_q    <= '0;
            out_data_q   <= '0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            in_ready_q   <= in_ready_d;
            rdy_flag_q   <= rdy_flag_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            s_addr_q     <= s_addr_d;
            g_addr_q     <= g_addr_d;
            sum_addr_q   <= sum_addr_d;
            s_we_q       <= s_we_d;
            g_we_q       <= g_we_d;
            sum_we_q     <= sum_we_d;
            s_wdata_q    <= s_wdata_d;
            g_wdata_q    <= g_wdata_d;
            out_data_q   <= out_data_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    // Next state plus next output values; outputs are computed for the state being entered
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        rdy_flag_d   = 1'b0;
        done_d       = 1'b0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        s_addr_d     = s_addr_q;
        g_addr_d     = g_addr_q;
        sum_addr_d   = sum_addr_q;
        s_we_d       = '0;
        g_we_d       = '0;
        sum_we_d     = '0;
        s_wdata_d    = s_wdata_q;
        g_wdata_d    = g_wdata_q;
        run_cycles_d = run_cycles_q;
        hs_in        = in_valid && in_ready_q;
        len_clamped  = (load_len > DEPTH_C) ? DEPTH_C : load_len;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d        = '0;
                    run_cycles_d = '0;
                    len_d        = len_clamped;
                    if (len_clamped == '0) begin
                        state_d    = CLR_SUM;
                        sum_we_d   = '1;
                        sum_addr_d = '0;
                    end else begin
                        state_d = LOAD_S;
                    end
                end
            end
            LOAD_S: begin
                if (hs_in) begin
                    s_we_d    = '1;
                    s_addr_d  = cnt_q[ADDR_WIDTH-1:0];
                    s_wdata_d = in_data;
                    if (cnt_q == len_q - CW'(1)) begin
                        cnt_d   = '0;
                        state_d = LOAD_G;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOAD_G: begin
                if (hs_in) begin
                    g_we_d    = '1;
                    g_addr_d  = cnt_q[ADDR_WIDTH-1:0];
                    g_wdata_d = in_data;
                    if (cnt_q == len_q - CW'(1)) begin
                        cnt_d      = '0;
                        state_d    = CLR_SUM;
                        sum_we_d   = '1;
                        sum_addr_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            CLR_SUM: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d      = '0;
                    state_d    = RUN;
                    rdy_flag_d = 1'b1;
                    s_addr_d   = '0;
                    g_addr_d   = '0;
                    sum_addr_d = '0;
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                    sum_we_d   = '1;
                    sum_addr_d = cnt_d[ADDR_WIDTH-1:0];
                end
            end
            RUN: begin
                if (run_cycles_q != '1) run_cycles_d = run_cycles_q + 32'd1;
                s_addr_d   = '0;
                g_addr_d   = '0;
                sum_addr_d = '0;
                if (diff_done) begin
                    cnt_d   = '0;
                    state_d = RD_ADDR;
                end else begin
                    rdy_flag_d = 1'b1;
                end
            end
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: begin
                out_data_d  = sum_rdata;
                out_valid_d = 1'b1;
                state_d     = RD_OUT;
            end
            RD_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (cnt_q == HALF_LAST) begin
                        state_d = DONE_S;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d      = cnt_q + CW'(1);
                        sum_addr_d = cnt_d[ADDR_WIDTH-1:0];
                        state_d    = RD_ADDR;
                    end
                end
            end
            DONE_S:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == LOAD_S) || (state_d == LOAD_G);
        busy_d     = (state_d != IDLE);
    end

    assign in_ready   = in_ready_q;
    assign s_addr     = s_addr_q;
    assign s_we       = s_we_q;
    assign s_wdata    = s_wdata_q;
    assign g_addr     = g_addr_q;
    assign g_we       = g_we_q;
    assign g_wdata    = g_wdata_q;
    assign sum_addr   = sum_addr_q;
    assign sum_we     = sum_we_q;
    assign sum_wdata  = '0;
    assign rdy_flag   = rdy_flag_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign run_cycles = run_cycles_q;
endmodule

// File: tb/tb_octa_load_sched.sv
// tb/tb_octa_load_sched.sv - self-checking bench for octa_load_sched
module tb_octa_load_sched;
    localparam int AW = 4;
    localparam int DP = 16;
    localparam int DWID = 32;
    localparam int PAR = 2;
    localparam int W = DWID * PAR;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [AW:0] load_len = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [W-1:0] in_data = '0;
    logic [AW-1:0] s_addr, g_addr, sum_addr;
    logic [PAR-1:0] s_we, g_we, sum_we;
    logic [W-1:0] s_wdata, g_wdata, sum_wdata, out_data;
    logic [W-1:0] sum_rdata = '0;
    logic rdy_flag, out_valid, busy, done;
    logic diff_done = 1'b0;
    logic out_ready = 1'b0;
    logic [31:0] run_cycles;

    int vecs = 0;
    int miscompares = 0;
    int cyc = 0;

    octa_load_sched #(.ADDR_WIDTH(AW), .DEPTH(DP), .DATA_WIDTH(DWID), .PARALLEL(PAR)) dut (
        .clk(clk), .rst(rst), .start(start), .load_len(load_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
        .g_addr(g_addr), .g_we(g_we), .g_wdata(g_wdata),
        .sum_addr(sum_addr), .sum_we(sum_we), .sum_wdata(sum_wdata), .sum_rdata(sum_rdata),
        .rdy_flag(rdy_flag), .diff_done(diff_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] beat_data(input int b);
        return {32'(2 * b + 1), 32'(2 * b)};
    endfunction

    function automatic logic [W-1:0] sum_word(input int j);
        return {32'(j + 116), 32'(j + 100)};
    endfunction

    // Score-sum BRAM: one-cycle read latency, fixed contents sum[j] = j+100 in bank 0
    always @(posedge clk) sum_rdata <= sum_word(int'(sum_addr));

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Session model: stream beats split into L score beats then L subgraph beats,
    // DEPTH/2 zero writes, a run window, then DEPTH/2 readback words in order
    int exp_len = 0, s_cnt = 0, g_cnt = 0, sum_cnt = 0, rd_cnt = 0, rdy_cnt = 0, done_cnt = 0;
    int first_s = -1, first_g = -1, first_sum = -1, first_rdy = -1, start_cyc = 0;
    logic [W-1:0] acc[$];
    logic [W-1:0] prev_data = '0, last_out = '0;
    bit prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            acc.delete();
            s_cnt = 0; g_cnt = 0; sum_cnt = 0; rd_cnt = 0; rdy_cnt = 0; done_cnt = 0;
            prev_stall = 1'b0;
        end else begin
            if (start && !busy) begin
                acc.delete();
                exp_len = (int'(load_len) > DP) ? DP : int'(load_len);
                s_cnt = 0; g_cnt = 0; sum_cnt = 0; rd_cnt = 0; rdy_cnt = 0; done_cnt = 0;
                first_s = -1; first_g = -1; first_sum = -1; first_rdy = -1;
                start_cyc = cyc;
                prev_stall = 1'b0;
            end
            if (in_valid && in_ready) begin
                chk("in_accept_room", W'(acc.size() < 2 * exp_len), W'(1));
                acc.push_back(in_data);
            end
            if (s_we != '0) begin
                if (first_s < 0) first_s = cyc;
                chk("s_we_all", W'(s_we), W'({PAR{1'b1}}));
                chk("s_addr", W'(s_addr), W'(s_cnt));
                if (s_cnt < acc.size()) chk("s_wdata", s_wdata, acc[s_cnt]);
                else chk("s_write_no_beat", W'(s_cnt), W'(acc.size()));
                s_cnt++;
            end
            if (g_we != '0) begin
                if (first_g < 0) first_g = cyc;
                chk("g_after_s", W'(s_cnt), W'(exp_len));
                chk("g_we_all", W'(g_we), W'({PAR{1'b1}}));
                chk("g_addr", W'(g_addr), W'(g_cnt));
                if (exp_len + g_cnt < acc.size()) chk("g_wdata", g_wdata, acc[exp_len + g_cnt]);
                else chk("g_write_no_beat", W'(exp_len + g_cnt), W'(acc.size()));
                g_cnt++;
            end
            if (sum_we != '0) begin
                if (first_sum < 0) first_sum = cyc;
                chk("sum_after_load", W'(g_cnt), W'(exp_len));
                chk("sum_we_all", W'(sum_we), W'({PAR{1'b1}}));
                chk("sum_addr", W'(sum_addr), W'(sum_cnt));
                chk("sum_wdata", sum_wdata, '0);
                sum_cnt++;
            end
            if (rdy_flag) begin
                if (first_rdy < 0) first_rdy = cyc;
                chk("rdy_after_clear", W'(sum_cnt), W'(DP / 2));
                chk("rdy_bus_quiet", W'({s_we, g_we, sum_we, s_addr, g_addr, sum_addr, out_valid}), '0);
                rdy_cnt++;
            end
            if (out_valid) begin
                if (prev_stall) chk("out_stable", out_data, prev_data);
                if (out_ready) begin
                    chk("out_word", out_data, sum_word(rd_cnt));
                    last_out = out_data;
                    rd_cnt++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            if (done) begin
                chk("done_after_read", W'(rd_cnt), W'(DP / 2));
                chk("run_cycles_eq_rdy", W'(run_cycles), W'(rdy_cnt));
                done_cnt++;
            end
        end
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, W'({in_ready, s_we, g_we, sum_we, rdy_flag, out_valid, busy, done}), '0);
        chk({nm, "_addr"}, W'({s_addr, g_addr, sum_addr}), '0);
        chk({nm, "_run_cycles"}, W'(run_cycles), '0);
        chk({nm, "_data"}, s_wdata | g_wdata | out_data, '0);
    endtask

    // abort_mode: 0 run to completion, 1 reset once subgraph writes start, 2 reset mid-RUN
    task automatic session(input int len_in, input bit gaps, input bit stalls,
                           input int run_len, input int abort_mode, input bit poke);
        int beat = 0;
        int seen_rdy = 0;
        int n = 0;
        bit fin = 1'b0;
        @(posedge clk); #1;
        load_len = (AW + 1)'(len_in);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!fin && n < 3000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = beat_data(beat);
            out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            diff_done = (rdy_flag && seen_rdy == run_len - 1) || (poke && in_ready);
            start = poke && rdy_flag && seen_rdy == 10;
            @(negedge clk);
            if (in_valid && in_ready) beat++;
            if (rdy_flag) seen_rdy++;
            if ((abort_mode == 1 && g_we != '0) || (abort_mode == 2 && rdy_flag && seen_rdy > 5)) begin
                #2 rst = 1'b1;
                #1 chk_all_zero("abort");
                @(negedge clk);
                @(posedge clk); #1;
                rst = 1'b0;
                in_valid = 1'b0;
                diff_done = 1'b0;
                start = 1'b0;
                return;
            end
            if (done) fin = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        diff_done = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        if (!fin) chk("session_timeout", W'(0), W'(1));
        chk("done_single", W'(done), W'(0));
        chk("busy_after_done", W'(busy), W'(0));
        chk("done_count", W'(done_cnt), W'(1));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        rst = 1'b0;

        // Full-length load, streaming without gaps
        session(16, 1'b0, 1'b0, 20, 0, 1'b0);
        chk("t1_s_writes", W'(s_cnt), W'(16));
        chk("t1_g_writes", W'(g_cnt), W'(16));
        chk("t1_s_latency", W'(first_s - start_cyc), W'(2));
        chk("t1_g_follows_s", W'(first_g - first_s), W'(16));
        chk("t1_sum_overlap", W'(first_sum - first_g), W'(15));
        chk("t1_rdy_after_clr", W'(first_rdy - first_sum), W'(8));
        chk("t1_sum_writes", W'(sum_cnt), W'(8));
        chk("t1_run_cycles", W'(run_cycles), W'(20));

        // Short load with random valid gaps; diff_done noise while loading
        session(5, 1'b1, 1'b0, 12, 0, 1'b1);
        chk("t2_s_writes", W'(s_cnt), W'(5));
        chk("t2_g_writes", W'(g_cnt), W'(5));
        chk("t2_run_cycles", W'(run_cycles), W'(12));

        // Empty load goes straight to clearing
        session(0, 1'b0, 1'b0, 3, 0, 1'b0);
        chk("t3_s_writes", W'(s_cnt), W'(0));
        chk("t3_g_writes", W'(g_cnt), W'(0));
        chk("t3_clr_first", W'(first_sum - start_cyc), W'(1));
        chk("t3_run_cycles", W'(run_cycles), W'(3));

        // 37-cycle run, start pulse during RUN, stalled readback
        session(16, 1'b0, 1'b1, 37, 0, 1'b1);
        chk("t4_run_cycles", W'(run_cycles), W'(37));
        chk("t4_rdy_cycles", W'(rdy_cnt), W'(37));
        chk("t4_words", W'(rd_cnt), W'(8));
        chk("t4_last_word", last_out, {32'd123, 32'd107});

        // Resets mid-LOAD_G and mid-RUN, then a fresh session with clamped length
        session(16, 1'b0, 1'b0, 20, 1, 1'b0);
        session(16, 1'b1, 1'b0, 100, 2, 1'b0);
        session(31, 1'b1, 1'b1, 5, 0, 1'b0);
        chk("t7_s_writes_clamped", W'(s_cnt), W'(16));
        chk("t7_g_writes_clamped", W'(g_cnt), W'(16));
        chk("t7_run_cycles", W'(run_cycles), W'(5));
        chk("t7_words", W'(rd_cnt), W'(8));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
